// File: rtl/dcp_pkg.sv
// dcp_pkg: shared types and constants for the DCP debug command units.
//   - dcp_state_e : register-dump sequencer states
//   - dcp_phase_e : which kind of word the sequencer is currently sending
//   - hs_state_e  : four-phase handshake engine states
//   - TERM_CHAR   : control word that closes a dump
//   - CMD_*_DEF   : default command codes ('T' = dump all, 'R' = dump one)
package dcp_pkg;

  typedef enum logic [2:0] {
    IDLE, SNAP, LOAD, REQ, WAITLO, TERM, DONE
  } dcp_state_e;

  typedef enum logic [1:0] {
    PH_INDEX, PH_DATA, PH_TERM
  } dcp_phase_e;

  typedef enum logic [1:0] {
    HS_IDLE, HS_REQ, HS_LO
  } hs_state_e;

  localparam logic [31:0] TERM_CHAR   = 32'h0000_000A;
  localparam logic [7:0]  CMD_ALL_DEF = 8'h54;
  localparam logic [7:0]  CMD_ONE_DEF = 8'h52;

endpackage

// File: rtl/dcp_tx_hs.sv
// dcp_tx_hs: four-phase req/ack handshake engine shared by DCP command units.
//   clk, rst : clock, synchronous active-high reset
//   go       : start one transfer (sampled only when idle)
//   ack_tx   : acknowledge from the TX path
//   req_tx   : registered request
//   done     : high in the cycle ack_tx is seen low after the request dropped;
//              the owner advances on this cycle
module dcp_tx_hs
  import dcp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic ack_tx,
  output logic req_tx,
  output logic done
);

  hs_state_e st_q, st_d;
  logic      req_q, req_d;

  always_comb begin
    st_d  = st_q;
    req_d = req_q;
    unique case (st_q)
      HS_IDLE: if (go) begin
        st_d  = HS_REQ;
        req_d = 1'b1;
      end
      // An ack that is already high is taken as the acknowledge.
      HS_REQ: if (ack_tx) begin
        st_d  = HS_LO;
        req_d = 1'b0;
      end
      HS_LO: if (!ack_tx) st_d = HS_IDLE;
      default: st_d = HS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= HS_IDLE;
      req_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      req_q <= req_d;
    end
  end

  assign req_tx = req_q;
  assign done   = (st_q == HS_LO) && !ack_tx;

endmodule

// File: rtl/dcp_reg_dump.sv
// dcp_reg_dump: debug register-dump sequencer for the serial debug unit.
// On a dump command, snapshots NUM_REGS datapath registers, holds the CPU and
// streams the words (then a TERM_CHAR control word) over a four-phase req/ack.
//   clk, rst  : clock, synchronous active-high reset
//   sel_mode  : command code (CMD_ALL dumps all, CMD_ONE dumps sel_idx)
//   sel_idx   : channel for CMD_ONE, clamped to NUM_REGS-1
//   regs_flat : channel k at [k*DATA_W +: DATA_W]
//   ack_tx    : TX acknowledge
//   req_tx    : TX request
//   type_tx   : 0 = data word, 1 = control/index word
//   dout      : TX payload, data zero-extended
//   finish    : one-cycle pulse at the end of a complete dump
//   cpu_hold  : high from snapshot to finish
// Build option DCP_DUMP_INDEX_EN: when defined, each data word is preceded by
// an index word {24'h0, idx[7:0]} with type_tx=1.
module dcp_reg_dump
  import dcp_pkg::*;
#(
  parameter int          NUM_REGS = 9,
  parameter int          DATA_W   = 32,
  parameter logic [7:0]  CMD_ALL  = CMD_ALL_DEF,
  parameter logic [7:0]  CMD_ONE  = CMD_ONE_DEF,
  localparam int         IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 sel_mode,
  input  logic [IDX_W-1:0]           sel_idx,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic                       ack_tx,
  output logic                       req_tx,
  output logic                       type_tx,
  output logic [31:0]                dout,
  output logic                       finish,
  output logic                       cpu_hold
);

`ifdef DCP_DUMP_INDEX_EN
  localparam dcp_phase_e FIRST_PH = PH_INDEX;
`else
  localparam dcp_phase_e FIRST_PH = PH_DATA;
`endif

  dcp_state_e                         state_q, state_d;
  dcp_phase_e                         phase_q, phase_d;
  logic                               armed_q, armed_d;
  logic                               one_q, one_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [IDX_W-1:0]                   last_q, last_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]    shadow_q, shadow_d;
  logic [31:0]                        dout_q, dout_d;
  logic                               type_q, type_d;
  logic                               finish_q, finish_d;
  logic                               hold_q, hold_d;

  logic             cmd_hit;
  logic [IDX_W-1:0] sel_clamp;
  logic             hs_go, hs_done;

  assign cmd_hit   = (sel_mode == CMD_ALL) || (sel_mode == CMD_ONE);
  assign sel_clamp = (int'(sel_idx) >= NUM_REGS) ? IDX_W'(NUM_REGS - 1) : sel_idx;
  // Both LOAD and TERM hand a prepared word to the handshake engine.
  assign hs_go     = (state_q == LOAD) || (state_q == TERM);

  dcp_tx_hs u_hs (
    .clk    (clk),
    .rst    (rst),
    .go     (hs_go),
    .ack_tx (ack_tx),
    .req_tx (req_tx),
    .done   (hs_done)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    armed_d  = armed_q;
    one_d    = one_q;
    idx_d    = idx_q;
    last_d   = last_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    type_d   = type_q;
    finish_d = 1'b0;
    hold_d   = hold_q;

    // Re-arm on any non-command code, in any state, so a held command fires once.
    if (!cmd_hit) armed_d = 1'b1;

    unique case (state_q)
      IDLE: if (armed_q && cmd_hit) begin
        state_d = SNAP;
        armed_d = 1'b0;
        one_d   = (sel_mode == CMD_ONE);
        hold_d  = 1'b1;
      end
      SNAP: begin
        shadow_d = regs_flat;
        idx_d    = one_q ? sel_clamp : '0;
        last_d   = one_q ? sel_clamp : IDX_W'(NUM_REGS - 1);
        phase_d  = FIRST_PH;
        state_d  = LOAD;
      end
      LOAD: begin
        if (phase_q == PH_INDEX) begin
          dout_d = {24'h0, 8'(idx_q)};
          type_d = 1'b1;
        end else begin
          dout_d = 32'(shadow_q[idx_q]);
          type_d = 1'b0;
        end
        state_d = REQ;
      end
      REQ: if (ack_tx) state_d = WAITLO;
      WAITLO: if (hs_done) begin
        unique case (phase_q)
          PH_INDEX: begin
            phase_d = PH_DATA;
            state_d = LOAD;
          end
          PH_DATA: begin
            if (idx_q == last_q) begin
              phase_d = PH_TERM;
              state_d = TERM;
            end else begin
              idx_d   = idx_q + 1'b1;
              phase_d = FIRST_PH;
              state_d = LOAD;
            end
          end
          default: begin
            finish_d = 1'b1;
            hold_d   = 1'b0;
            state_d  = DONE;
          end
        endcase
      end
      TERM: begin
        dout_d  = TERM_CHAR;
        type_d  = 1'b1;
        state_d = REQ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= PH_DATA;
      armed_q  <= 1'b1;
      one_q    <= 1'b0;
      idx_q    <= '0;
      last_q   <= '0;
      dout_q   <= '0;
      type_q   <= 1'b0;
      finish_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      armed_q  <= armed_d;
      one_q    <= one_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      type_q   <= type_d;
      finish_q <= finish_d;
      hold_q   <= hold_d;
    end
  end

  assign type_tx  = type_q;
  assign dout     = dout_q;
  assign finish   = finish_q;
  assign cpu_hold = hold_q;

endmodule

// File: tb/tb_dcp_reg_dump.sv
module tb_dcp_reg_dump;

  localparam int NR = 9;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        sel_mode;
  logic [3:0]        sel_idx;
  logic [NR*DW-1:0]  regs_flat;
  logic              ack_tx;
  logic              req_tx, type_tx, finish, cpu_hold;
  logic [31:0]       dout;

  dcp_reg_dump #(.NUM_REGS(NR), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .sel_mode(sel_mode), .sel_idx(sel_idx),
    .regs_flat(regs_flat), .ack_tx(ack_tx), .req_tx(req_tx),
    .type_tx(type_tx), .dout(dout), .finish(finish), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Background monitors: finish pulses and req_tx rising edges.
  int   fin_cnt  = 0;
  int   rise_cnt = 0;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (finish === 1'b1) fin_cnt <= fin_cnt + 1;
    if (req_tx === 1'b1 && req_prev === 1'b0) rise_cnt <= rise_cnt + 1;
    req_prev <= req_tx;
  end

  logic [31:0] vals [NR];
  logic [31:0] got_d [64];
  logic        got_t [64];
  int          got_n;
  logic        tmo;
  logic [31:0] exp_d [$];
  logic        exp_t [$];

  function automatic void load_regs(input logic [31:0] base);
    for (int k = 0; k < NR; k++) begin
      vals[k] = base + 32'(k + 1);
      regs_flat[k*DW +: DW] = vals[k];
    end
  endfunction

  function automatic void build_exp(input int first, input int last);
    exp_d.delete();
    exp_t.delete();
    for (int k = first; k <= last; k++) begin
`ifdef DCP_DUMP_INDEX_EN
      exp_d.push_back(32'(k));
      exp_t.push_back(1'b1);
`endif
      exp_d.push_back(vals[k]);
      exp_t.push_back(1'b0);
    end
    exp_d.push_back(32'h0000_000A);
    exp_t.push_back(1'b1);
  endfunction

  // TX-side responder: records words and acknowledges them.
  task automatic rx_dump(input int hi, input int lo, input int maxw);
    int  n = 0;
    bit  fin = 0;
    tmo = 1'b0;
    while (!fin && !tmo) begin
      for (int c = 0; c < 300 && req_tx !== 1'b1; c++) @(negedge clk);
      if (req_tx !== 1'b1) begin tmo = 1'b1; break; end
      got_d[got_n] = dout;
      got_t[got_n] = type_tx;
      got_n++;
      n++;
      ack_tx = 1'b1;
      repeat (hi) @(negedge clk);
      for (int c = 0; c < 300 && req_tx !== 1'b0; c++) @(negedge clk);
      if (req_tx !== 1'b0) begin tmo = 1'b1; break; end
      ack_tx = 1'b0;
      repeat (lo) @(negedge clk);
      if ((got_t[got_n-1] === 1'b1 && got_d[got_n-1] === 32'h0A) || n >= maxw || got_n >= 60)
        fin = 1;
    end
  endtask

  task automatic idle_cmd();
    sel_mode = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (req_tx !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", req_tx); end
    total++; if (type_tx !== 1'b0) begin bad++; $display("FAIL rst_type got=%b exp=0", type_tx); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL rst_dout got=%h exp=0", dout); end
    total++; if (finish !== 1'b0) begin bad++; $display("FAIL rst_finish got=%b exp=0", finish); end
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL rst_hold got=%b exp=0", cpu_hold); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dump_all();
    int lat = 0;
    int f0;
    load_regs(32'h0);
    build_exp(0, NR-1);
    f0 = fin_cnt;
    sel_mode = 8'h54;
    for (int c = 0; c < 10 && req_tx !== 1'b1; c++) begin @(negedge clk); lat++; end
    total++; if (lat !== 3) begin bad++; $display("FAIL all_latency got=%0d exp=3", lat); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL all_hold_on got=%b exp=1", cpu_hold); end
    got_n = 0;
    rx_dump(10, 10, 64);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL all_timeout got=%b exp=0", tmo); end
    total++; if (got_n !== exp_d.size()) begin bad++; $display("FAIL all_count got=%0d exp=%0d", got_n, exp_d.size()); end
    for (int i = 0; i < got_n && i < exp_d.size(); i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_t[i] !== exp_t[i]) begin
        bad++; $display("FAIL all_word%0d got=%h/%b exp=%h/%b", i, got_d[i], got_t[i], exp_d[i], exp_t[i]);
      end
    end
    total++; if (fin_cnt - f0 !== 1) begin bad++; $display("FAIL all_finish got=%0d exp=1", fin_cnt - f0); end
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL all_hold_off got=%b exp=0", cpu_hold); end
    idle_cmd();
  endtask

  task automatic test_dump_one();
    // In range, then out of range (12 clamps to channel 8).
    for (int t = 0; t < 2; t++) begin
      sel_idx  = (t == 0) ? 4'd4 : 4'd12;
      build_exp((t == 0) ? 4 : 8, (t == 0) ? 4 : 8);
      sel_mode = 8'h52;
      got_n = 0;
      rx_dump(3, 3, 64);
      total++; if (tmo !== 1'b0) begin bad++; $display("FAIL one%0d_timeout got=%b exp=0", t, tmo); end
      total++; if (got_n !== exp_d.size()) begin bad++; $display("FAIL one%0d_count got=%0d exp=%0d", t, got_n, exp_d.size()); end
      for (int i = 0; i < got_n && i < exp_d.size(); i++) begin
        total++;
        if (got_d[i] !== exp_d[i] || got_t[i] !== exp_t[i]) begin
          bad++; $display("FAIL one%0d_word%0d got=%h/%b exp=%h/%b", t, i, got_d[i], got_t[i], exp_d[i], exp_t[i]);
        end
      end
      idle_cmd();
    end
    sel_idx = 4'd0;
  endtask

  task automatic test_held_cmd();
    int r0, f0;
    build_exp(0, NR-1);
    r0 = rise_cnt;
    f0 = fin_cnt;
    sel_mode = 8'h54;
    got_n = 0;
    rx_dump(1, 2, 64);
    repeat (500) @(negedge clk);
    total++; if (rise_cnt - r0 !== exp_d.size()) begin bad++; $display("FAIL held_reqs got=%0d exp=%0d", rise_cnt - r0, exp_d.size()); end
    total++; if (fin_cnt - f0 !== 1) begin bad++; $display("FAIL held_finish got=%0d exp=1", fin_cnt - f0); end
    idle_cmd();
    sel_mode = 8'h54;
    got_n = 0;
    rx_dump(1, 2, 64);
    total++; if (got_n !== exp_d.size()) begin bad++; $display("FAIL rearm_count got=%0d exp=%0d", got_n, exp_d.size()); end
    total++; if (fin_cnt - f0 !== 2) begin bad++; $display("FAIL rearm_finish got=%0d exp=2", fin_cnt - f0); end
    idle_cmd();
  endtask

  task automatic test_reset_mid();
    int r0, f0;
    f0 = fin_cnt;
    sel_mode = 8'h54;
    got_n = 0;
    rx_dump(2, 2, 2);
    for (int c = 0; c < 20 && req_tx !== 1'b1; c++) @(negedge clk);
    total++; if (req_tx !== 1'b1) begin bad++; $display("FAIL mid_req3 got=%b exp=1", req_tx); end
    rst = 1'b1;
    sel_mode = 8'h00;
    @(negedge clk);
    total++; if (req_tx !== 1'b0) begin bad++; $display("FAIL mid_req_drop got=%b exp=0", req_tx); end
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL mid_hold got=%b exp=0", cpu_hold); end
    rst = 1'b0;
    r0 = rise_cnt;
    repeat (20) @(negedge clk);
    total++; if (rise_cnt !== r0) begin bad++; $display("FAIL mid_idle_reqs got=%0d exp=%0d", rise_cnt, r0); end
    total++; if (fin_cnt !== f0) begin bad++; $display("FAIL mid_finish got=%0d exp=%0d", fin_cnt, f0); end
  endtask

  task automatic test_snapshot();
    load_regs(32'h0);
    build_exp(0, NR-1);
    sel_mode = 8'h54;
    got_n = 0;
    rx_dump(2, 2, 1);
    // New register values and a dropped command must not disturb the dump.
    load_regs(32'hDEAD_0000);
    sel_mode = 8'h00;
    rx_dump(2, 2, 64);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL snap_timeout got=%b exp=0", tmo); end
    total++; if (got_n !== exp_d.size()) begin bad++; $display("FAIL snap_count got=%0d exp=%0d", got_n, exp_d.size()); end
    for (int i = 0; i < got_n && i < exp_d.size(); i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_t[i] !== exp_t[i]) begin
        bad++; $display("FAIL snap_word%0d got=%h/%b exp=%h/%b", i, got_d[i], got_t[i], exp_d[i], exp_t[i]);
      end
    end
    load_regs(32'h0);
    idle_cmd();
  endtask

  task automatic test_ack_early();
    int f0;
    build_exp(0, 0);
    f0 = fin_cnt;
    ack_tx   = 1'b1;
    sel_idx  = 4'd0;
    sel_mode = 8'h52;
    repeat (3) @(negedge clk);
    total++; if (req_tx !== 1'b1 || dout !== exp_d[0] || type_tx !== exp_t[0]) begin
      bad++; $display("FAIL early_first got=%b/%h/%b exp=1/%h/%b", req_tx, dout, type_tx, exp_d[0], exp_t[0]);
    end
    @(negedge clk);
    total++; if (req_tx !== 1'b0) begin bad++; $display("FAIL early_consumed got=%b exp=0", req_tx); end
    ack_tx = 1'b0;
    got_n = 0;
    rx_dump(2, 3, 64);
    total++; if (got_n !== exp_d.size() - 1) begin bad++; $display("FAIL early_count got=%0d exp=%0d", got_n, exp_d.size() - 1); end
    for (int i = 0; i < got_n && i + 1 < exp_d.size(); i++) begin
      total++;
      if (got_d[i] !== exp_d[i+1] || got_t[i] !== exp_t[i+1]) begin
        bad++; $display("FAIL early_word%0d got=%h/%b exp=%h/%b", i, got_d[i], got_t[i], exp_d[i+1], exp_t[i+1]);
      end
    end
    total++; if (fin_cnt - f0 !== 1) begin bad++; $display("FAIL early_finish got=%0d exp=1", fin_cnt - f0); end
    idle_cmd();
  endtask

  initial begin
    rst       = 1'b1;
    sel_mode  = 8'h00;
    sel_idx   = 4'd0;
    ack_tx    = 1'b0;
    regs_flat = '0;
    got_n     = 0;
    tmo       = 1'b0;
    test_reset();
    test_dump_all();
    test_dump_one();
    test_held_cmd();
    test_reset_mid();
    test_snapshot();
    test_ack_early();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
